// File: rtl/i2c_fifo.sv
// Byte FIFO between the register block and the I2C core, with level status and
// sticky overflow/underflow flags. Pointers carry an extra wrap bit to tell full from empty.
module i2c_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLOCK_i,
    input  logic                  RESET_i,
    input  logic                  CLEAR_i,
    input  logic                  WRITE_EN_i,
    input  logic [DATA_WIDTH-1:0] DATA_i,
    input  logic                  READ_EN_i,
    output logic [DATA_WIDTH-1:0] DATA_o,
    output logic                  FULL_o,
    output logic                  EMPTY_o,
    output logic [ADDR_WIDTH:0]   COUNT_o,
    output logic                  OVERFLOW_o,
    output logic                  UNDERFLOW_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic full, empty, wr_acc, rd_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

    // A read draining a full FIFO frees the slot the concurrent write lands in.
    assign rd_acc = READ_EN_i & ~empty & ~CLEAR_i;
    assign wr_acc = WRITE_EN_i & (~full | rd_acc) & ~CLEAR_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (CLEAR_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            data_d   = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                data_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
            if (WRITE_EN_i && !wr_acc) begin
                ovf_d = 1'b1;
            end
            if (READ_EN_i && !rd_acc) begin
                unf_d = 1'b1;
            end
        end
    end

    // Storage has no reset; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge CLOCK_i) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= DATA_i;
        end
    end

    always_ff @(posedge CLOCK_i or posedge RESET_i) begin
        if (RESET_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign DATA_o      = data_q;
    assign FULL_o      = full;
    assign EMPTY_o     = empty;
    assign COUNT_o     = wr_ptr_q - rd_ptr_q;
    assign OVERFLOW_o  = ovf_q;
    assign UNDERFLOW_o = unf_q;

endmodule

// File: tb/tb_i2c_fifo.sv
// Directed testbench for i2c_fifo: fill/drain, overflow, underflow, full read+write,
// pointer wrap, asynchronous reset and synchronous clear.
module tb_i2c_fifo;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       ovf;
    logic       unf;

    int checks = 0;
    int errors = 0;

    i2c_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .CLOCK_i    (clk),
        .RESET_i    (rst),
        .CLEAR_i    (clear),
        .WRITE_EN_i (wr_en),
        .DATA_i     (din),
        .READ_EN_i  (rd_en),
        .DATA_o     (dout),
        .FULL_o     (full),
        .EMPTY_o    (empty),
        .COUNT_o    (count),
        .OVERFLOW_o (ovf),
        .UNDERFLOW_o(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the current inputs across one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
        $display("txn t=%0t clr=%0b wr=%0b din=%02h rd=%0b -> dout=%02h cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                 $time, clear, wr_en, din, rd_en, dout, count, full, empty, ovf, unf);
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 4'd0) begin $display("FAIL reset_count got %0d want 0", count); errors++; end
        checks++; if (empty !== 1'b1) begin $display("FAIL reset_empty got %0b want 1", empty); errors++; end
        checks++; if (full !== 1'b0) begin $display("FAIL reset_full got %0b want 0", full); errors++; end
        checks++; if (dout !== 8'h00) begin $display("FAIL reset_dout got %02h want 00", dout); errors++; end
        checks++; if ({ovf, unf} !== 2'b00) begin $display("FAIL reset_flags got %02b want 00", {ovf, unf}); errors++; end
        rst = 1'b0;
        step();
        checks++; if (empty !== 1'b1) begin $display("FAIL post_reset_empty got %0b want 1", empty); errors++; end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            din   = 8'(8'h11 * i);
            step();
            checks++; if (count !== 4'(i)) begin $display("FAIL fill_count got %0d want %0d", count, i); errors++; end
        end
        idle();
        checks++; if (full !== 1'b1) begin $display("FAIL fill_full got %0b want 1", full); errors++; end
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            step();
            checks++; if (dout !== 8'(8'h11 * i)) begin $display("FAIL drain_data got %02h want %02h", dout, 8'(8'h11 * i)); errors++; end
        end
        idle();
        checks++; if (empty !== 1'b1) begin $display("FAIL drain_empty got %0b want 1", empty); errors++; end
        checks++; if ({ovf, unf} !== 2'b00) begin $display("FAIL drain_flags got %02b want 00", {ovf, unf}); errors++; end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            din   = 8'(8'h21 + i);
            step();
        end
        din = 8'hAA;
        step();
        idle();
        checks++; if (ovf !== 1'b1) begin $display("FAIL ovf_set got %0b want 1", ovf); errors++; end
        checks++; if (count !== 4'd8) begin $display("FAIL ovf_count got %0d want 8", count); errors++; end
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            checks++; if (dout !== 8'(8'h21 + i)) begin $display("FAIL ovf_drain got %02h want %02h", dout, 8'(8'h21 + i)); errors++; end
        end
        idle();
        checks++; if (ovf !== 1'b1) begin $display("FAIL ovf_sticky got %0b want 1", ovf); errors++; end
        clear = 1'b1;
        step();
        idle();
        checks++; if (ovf !== 1'b0) begin $display("FAIL clear_ovf got %0b want 0", ovf); errors++; end
        checks++; if (count !== 4'd0) begin $display("FAIL clear_count got %0d want 0", count); errors++; end
        checks++; if (dout !== 8'h00) begin $display("FAIL clear_dout got %02h want 00", dout); errors++; end
    endtask

    task automatic test_underflow();
        wr_en = 1'b1;
        din   = 8'h3E;
        step();
        idle();
        rd_en = 1'b1;
        step();
        checks++; if (dout !== 8'h3E) begin $display("FAIL unf_prep got %02h want 3e", dout); errors++; end
        step();
        idle();
        checks++; if (unf !== 1'b1) begin $display("FAIL unf_set got %0b want 1", unf); errors++; end
        checks++; if (dout !== 8'h3E) begin $display("FAIL unf_hold got %02h want 3e", dout); errors++; end
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 8'h5C;
        step();
        idle();
        checks++; if (count !== 4'd1) begin $display("FAIL empty_rw_count got %0d want 1", count); errors++; end
        checks++; if (dout !== 8'h3E) begin $display("FAIL empty_rw_nofall got %02h want 3e", dout); errors++; end
        rd_en = 1'b1;
        step();
        idle();
        checks++; if (dout !== 8'h5C) begin $display("FAIL empty_rw_read got %02h want 5c", dout); errors++; end
        checks++; if (empty !== 1'b1) begin $display("FAIL empty_rw_empty got %0b want 1", empty); errors++; end
        clear = 1'b1;
        step();
        idle();
        checks++; if (unf !== 1'b0) begin $display("FAIL clear_unf got %0b want 0", unf); errors++; end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            din   = 8'(8'h31 + i);
            step();
        end
        rd_en = 1'b1;
        din   = 8'h99;
        step();
        idle();
        checks++; if (dout !== 8'h31) begin $display("FAIL full_rw_data got %02h want 31", dout); errors++; end
        checks++; if (count !== 4'd8) begin $display("FAIL full_rw_count got %0d want 8", count); errors++; end
        checks++; if (full !== 1'b1) begin $display("FAIL full_rw_full got %0b want 1", full); errors++; end
        checks++; if (ovf !== 1'b0) begin $display("FAIL full_rw_ovf got %0b want 0", ovf); errors++; end
        for (int i = 1; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            checks++; if (dout !== 8'(8'h31 + i)) begin $display("FAIL full_rw_drain got %02h want %02h", dout, 8'(8'h31 + i)); errors++; end
        end
        step();
        idle();
        checks++; if (dout !== 8'h99) begin $display("FAIL full_rw_last got %02h want 99", dout); errors++; end
        checks++; if (empty !== 1'b1) begin $display("FAIL full_rw_empty got %0b want 1", empty); errors++; end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] val;
        logic [7:0] exp;
        logic       w;
        logic       r;
        val = 8'h40;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            din   = val;
            step();
            q.push_back(val);
            val++;
        end
        for (int i = 0; i < 20; i++) begin
            w = (i % 3 != 2);
            r = (i % 3 != 0);
            wr_en = w;
            rd_en = r;
            din   = val;
            step();
            if (w) begin
                q.push_back(val);
                val++;
            end
            if (r) begin
                exp = q.pop_front();
                checks++; if (dout !== exp) begin $display("FAIL wrap_data got %02h want %02h", dout, exp); errors++; end
            end
            checks++; if (count !== 4'(q.size()) || count > 4'd8) begin $display("FAIL wrap_count got %0d want %0d", count, q.size()); errors++; end
        end
        wr_en = 1'b0;
        while (q.size() > 0) begin
            rd_en = 1'b1;
            step();
            exp = q.pop_front();
            checks++; if (dout !== exp) begin $display("FAIL wrap_drain got %02h want %02h", dout, exp); errors++; end
        end
        idle();
        checks++; if ({empty, ovf, unf} !== 3'b100) begin $display("FAIL wrap_end got %03b want 100", {empty, ovf, unf}); errors++; end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            din   = 8'(8'hC1 + i);
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        idle();
        checks++; if (count !== 4'd5 || dout !== 8'hC1) begin $display("FAIL pre_rst got cnt=%0d dout=%02h want cnt=5 dout=c1", count, dout); errors++; end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (empty !== 1'b1) begin $display("FAIL async_rst_empty got %0b want 1", empty); errors++; end
        checks++; if (count !== 4'd0) begin $display("FAIL async_rst_count got %0d want 0", count); errors++; end
        checks++; if (dout !== 8'h00) begin $display("FAIL async_rst_dout got %02h want 00", dout); errors++; end
        #1;
        rst = 1'b0;
        step();
    endtask

    task automatic test_clear_write();
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1;
            din   = 8'(8'hD0 + i);
            step();
        end
        clear = 1'b1;
        rd_en = 1'b1;
        din   = 8'h77;
        step();
        idle();
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin $display("FAIL clear_wr_level got cnt=%0d empty=%0b want 0/1", count, empty); errors++; end
        checks++; if ({ovf, unf} !== 2'b00) begin $display("FAIL clear_wr_flags got %02b want 00", {ovf, unf}); errors++; end
        rd_en = 1'b1;
        step();
        idle();
        checks++; if (dout !== 8'h00 || unf !== 1'b1) begin $display("FAIL clear_wr_discard got dout=%02h unf=%0b want 00/1", dout, unf); errors++; end
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_full_rw();
        test_wrap();
        test_async_reset();
        test_clear_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
